// File: rtl/encoder_stream.sv
// encoder_stream: valid/ready stream encoder (one-hot, gray, binary, thermometer)
// with a 2-entry skid buffer on the output and a completed-transaction counter.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data (IN_W) and in_mode (2) sampled on transfer
//   out_valid/out_ready : output handshake; out_data (OUT_W) and out_mode (2) held while stalled
//   cnt_clr             : synchronous clear of out_count and cnt_wrap (wins over a handshake)
//   out_count, cnt_wrap : output handshakes modulo 2**CNT_W, sticky wrap flag
module encoder_stream #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] out_count,
    output logic             cnt_wrap
);

    logic [OUT_W-1:0] enc;
    logic             acc, out_hs;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
    logic [OUT_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [1:0]       main_mode_q, main_mode_d, skid_mode_q, skid_mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        enc = '0;
        case (in_mode)
            2'b00:   for (int i = 0; i < OUT_W; i++) enc[i] = (int'(in_data) == i + 1);
            2'b01:   enc = OUT_W'(in_data ^ (in_data >> 1));
            2'b10:   enc = OUT_W'(in_data);
            default: for (int i = 0; i < OUT_W; i++) enc[i] = (i < int'(in_data));
        endcase
    end

    // in_ready_q mirrors "skid empty", so an accept never arrives while skid is full.
    always_comb begin
        acc         = in_valid && in_ready_q;
        out_hs      = main_v_q && out_ready;
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_mode_d = main_mode_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_mode_d = skid_mode_q;
        if (skid_v_q) begin
            if (out_hs) begin
                main_data_d = skid_data_q;
                main_mode_d = skid_mode_q;
                skid_v_d    = 1'b0;
            end
        end else if (acc && main_v_q && !out_ready) begin
            skid_v_d    = 1'b1;
            skid_data_d = enc;
            skid_mode_d = in_mode;
        end else if (acc) begin
            main_v_d    = 1'b1;
            main_data_d = enc;
            main_mode_d = in_mode;
        end else if (out_hs) begin
            main_v_d = 1'b0;
        end
        in_ready_d = !skid_v_d;
        cnt_d      = cnt_clr ? '0 : out_hs ? cnt_q + 1'b1 : cnt_q;
        wrap_d     = cnt_clr ? 1'b0 : wrap_q || (out_hs && &cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_mode_q <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_mode_q <= '0;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_mode_q <= main_mode_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_mode_q <= skid_mode_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_mode  = main_mode_q;
    assign out_count = cnt_q;
    assign cnt_wrap  = wrap_q;

endmodule

// File: doc/encoder_stream.md
Name: encoder_stream

Overview:
- Parametrised, pipelined successor to the combinational 3-to-7 encoder.
- Accepts an N-bit code on a valid/ready input stream and encodes it in one of four per-transaction modes: one-hot, gray, binary, thermometer.
- Drives the result on a valid/ready output stream through a 2-entry skid buffer.
- Counts completed output transactions.
- Sits between a producer that cannot tolerate dropped data and a consumer that may stall.

Parameters:
- IN_W, 3, input code width; legal range 2..6.
- OUT_W, 7, output width; must be >= 2**IN_W - 1. Upper bits beyond the encoding are zero.
- CNT_W, 8, width of the transaction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has data
- in_ready  output  1  block can accept data
- in_data  input  IN_W  code A
- in_mode  input  2  00 one-hot, 01 gray, 10 binary, 11 thermometer; sampled with in_data
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts data
- out_data  output  OUT_W  encoded result
- out_mode  output  2  mode used for out_data
- cnt_clr  input  1  synchronous clear of count and wrap flag
- out_count  output  CNT_W  number of completed output handshakes, modulo 2**CNT_W
- cnt_wrap  output  1  sticky; set when out_count wraps from all-ones to 0

Behaviour:
- Encoding is computed combinationally at acceptance and stored already encoded, together with its mode.
  - One-hot: A=0 gives 0; A=k (k>=1) gives 1<<(k-1). Example for IN_W=3: 3 gives 0000100, 7 gives 1000000.
  - Gray: A ^ (A>>1), zero-extended.
  - Binary: A, zero-extended.
  - Thermometer: (1<<A)-1. Example: 0 gives 0, 3 gives 0000111, 7 gives 1111111.
- Input handshake: a transfer occurs on a rising edge with in_valid && in_ready. Output handshake: a transfer occurs on a rising edge with out_valid && out_ready.
- Storage is a main register (drives the outputs) plus a skid register.
  - Main empty, input accepted: the word goes to main. out_valid rises on the next cycle (1-cycle latency).
  - Main full, out_ready=1, input accepted: main is replaced by the new word; out_valid stays 1.
  - Main full, out_ready=0, input accepted: the word goes to skid.
  - Skid full, output handshake: skid moves to main; skid becomes empty.
- in_ready is a register. It is 0 when skid is full or will become full on this edge, otherwise 1.
- Never drop, duplicate or reorder words. Words change out_data only on an output handshake or when main is empty.
- While out_valid=1 and out_ready=0, out_data and out_mode hold stable.
- in_data and in_mode are ignored when in_ready=0 or in_valid=0.
- Counter:
  - out_count increments by 1 per output handshake.
  - Going from all-ones to 0 sets cnt_wrap, which stays set until cleared.
  - cnt_clr=1 forces out_count=0 and cnt_wrap=0 on that edge. Clear has priority over a simultaneous handshake, and that handshake is not counted.
- Reset (rst_n=0, asynchronous, any point):
  - in_ready=0, out_valid=0, out_data=0, out_mode=00, out_count=0, cnt_wrap=0.
  - Both storage registers become empty; in-flight words are discarded.
  - in_ready becomes 1 on the first rising edge after rst_n deasserts.

Test Plan:
- Reset, out_ready=1, IN_W=3, mode 00; stream A=0..7 back-to-back, in_valid=1 -> out_data 0,1,2,4,8,16,32,64 on consecutive cycles, each 1 cycle after acceptance; out_count=8.
- Same stream in modes 01/10/11 -> gray 0,1,3,2,6,7,5,4; binary 0..7; thermometer 0,1,3,7,15,31,63,127. out_mode matches the mode of each word.
- Backpressure: send A=1,2,3 (mode 00) with out_ready=0 -> out_data holds 0000001; in_ready=0 after 2 accepted. Raise out_ready -> outputs 1,2,4 in order, no loss; in_ready returns to 1.
- Random in_valid/out_ready over 1000 words -> output sequence equals the encoded input sequence exactly; out_count equals the handshake count mod 256.
- CNT_W=4: complete 16 handshakes -> out_count=0, cnt_wrap=1. Assert cnt_clr in the same cycle as handshake 17 -> out_count=0, cnt_wrap=0.
- Assert rst_n=0 mid-stream with skid full -> all outputs 0 immediately, without a clock edge. After release: in_ready=1 one edge later, and the first new word A=5 in mode 00 gives out_data=0010000.
